// File: rtl/sdio_crc16.sv
// ---------------------------------------------------------------------------
// sdio_crc16
//
// Serial CRC-16 (CRC-CCITT polynomial x^16 + x^12 + x^5 + 1, XMODEM form:
// init 0, no reflection, no final XOR) for one SD data line. One instance sits
// on each of DAT0..DAT3 in the SDIO data PHY. The running remainder is always
// visible so the PHY can shift it out after a read block, or check it after a
// write block. Feeding data then the received CRC (MSB first) leaves zero when
// the block is error-free.
//
// Ports:
//   clk       data-bit clock, all state updates on the rising edge
//   rst       asynchronous active-low reset, clears the remainder; this is
//             also how the PHY restarts the CRC for a new block
//   en        shift enable; when high, data_bit is absorbed on this edge
//   data_bit  serial data bit, MSB of each byte first (SD bus order). This is
//             the SD "bit" line; "bit" is a SystemVerilog keyword, so the
//             port carries a longer name.
//   crc       current CRC remainder, registered
//   crc_zero  (only with SDIO_CRC16_ZERO_EN) high when crc == 16'h0000;
//             combinational from the crc register, used as good-CRC flag
//
// Configuration macro: SDIO_CRC16_ZERO_EN adds the crc_zero output. The CRC
// datapath is identical with or without it.
//
// There is no bit counter and no framing logic here; framing belongs to the
// PHY. Idle cycles (en low) simply hold the remainder.
// ---------------------------------------------------------------------------
module sdio_crc16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        data_bit,
`ifdef SDIO_CRC16_ZERO_EN
  output logic [15:0] crc,
  output logic        crc_zero
`else
  output logic [15:0] crc
`endif
);

  // Generator polynomial without the implicit x^16 term.
  localparam logic [15:0] POLY = 16'h1021;

  logic        feedback;
  logic [15:0] crc_next;

  // Galois-style serial update: the incoming bit is combined with the
  // outgoing MSB and, if set, the polynomial taps are folded into the
  // shifted remainder.
  always_comb begin
    feedback = data_bit ^ crc[15];
    crc_next = {crc[14:0], 1'b0} ^ (feedback ? POLY : 16'h0000);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create simulation races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc <= 16'h0000;
    end else if (en) begin
      crc <= crc_next;
    end
  end

`ifdef SDIO_CRC16_ZERO_EN
  assign crc_zero = (crc == 16'h0000);
`endif

endmodule

// File: tb/tb_sdio_crc16.sv
// ---------------------------------------------------------------------------
// tb_sdio_crc16
//
// Self-checking bench for sdio_crc16. Stimulus pushes expected remainders into
// a scoreboard queue and raises chk_req alongside the bit that should produce
// them; a monitor on the falling clock edge pops and compares. The reference
// model computes the CRC as the remainder of M(x)*x^16 divided by G(x) using
// polynomial long division over a bit array.
// ---------------------------------------------------------------------------
module tb_sdio_crc16;

  typedef logic bitq_t[$];

  typedef struct {
    string       name;
    logic [15:0] crc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic        data_bit;
  logic [15:0] crc;
`ifdef SDIO_CRC16_ZERO_EN
  logic        crc_zero;
`endif

  logic        chk_req;
  exp_t        sb[$];
  int          tests_run;
  int          tests_failed;

  sdio_crc16 dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .data_bit (data_bit),
`ifdef SDIO_CRC16_ZERO_EN
    .crc      (crc),
    .crc_zero (crc_zero)
`else
    .crc      (crc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Remainder of (message * x^16) mod (x^16 + x^12 + x^5 + 1), MSB first.
  function automatic logic [15:0] ref_crc(input bitq_t m);
    logic        w[];
    logic [16:0] g;
    logic [15:0] r;
    int          n;
    n = m.size();
    g = 17'h11021;
    w = new[n + 16];
    for (int i = 0; i < n + 16; i++) w[i] = (i < n) ? m[i] : 1'b0;
    for (int i = 0; i < n; i++) begin
      if (w[i]) begin
        for (int j = 0; j <= 16; j++) w[i + j] = w[i + j] ^ g[16 - j];
      end
    end
    for (int k = 0; k < 16; k++) r[15 - k] = w[n + k];
    return r;
  endfunction

  // Monitor: compares after every edge where stimulus flagged a check.
  always @(negedge clk) begin
    if (chk_req) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 16'd1, 16'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.name, crc, e.crc);
`ifdef SDIO_CRC16_ZERO_EN
        check({e.name, "_zero"}, {15'd0, crc_zero}, {15'd0, (e.crc == 16'h0000)});
`endif
      end
    end
  end

  // Inputs change 1 time unit after the falling edge, well clear of the
  // rising edge that samples them and of the monitor's sampling point.
  task automatic drive(input logic e, input logic b, input logic c);
    @(negedge clk);
    #1;
    en       = e;
    data_bit = b;
    chk_req  = c;
  endtask

  task automatic shift_chk(input logic b, input string name, input logic [15:0] expv);
    exp_t e;
    e.name = name;
    e.crc  = expv;
    sb.push_back(e);
    drive(1'b1, b, 1'b1);
  endtask

  task automatic idle_gap(input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b0, 1'($urandom), 1'b0);
  endtask

  // Shift a whole bit stream; optionally insert random idle gaps; check the
  // final remainder against expv on the last bit.
  task automatic feed(input bitq_t m, input bit gaps, input string name, input logic [15:0] expv);
    for (int i = 0; i < m.size(); i++) begin
      if (gaps && i > 0) idle_gap(int'($urandom_range(1, 5)));
      if (i == m.size() - 1) shift_chk(m[i], name, expv);
      else                   drive(1'b1, m[i], 1'b0);
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    #1;
    en      = 1'b0;
    chk_req = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic bitq_t bytes_to_bits(input logic [7:0] b[$]);
    bitq_t q;
    for (int i = 0; i < b.size(); i++)
      for (int k = 7; k >= 0; k--) q.push_back(b[i][k]);
    return q;
  endfunction

  function automatic bitq_t word_bits(input logic [15:0] w);
    bitq_t q;
    for (int k = 15; k >= 0; k--) q.push_back(w[k]);
    return q;
  endfunction

  initial begin
    logic [7:0]  ascii[$];
    bitq_t       ascii_bits;
    bitq_t       ones;
    bitq_t       tmp;
    bitq_t       msg;
    bitq_t       prefix;
    logic [15:0] r;
    int          len;

    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    en           = 1'b0;
    data_bit     = 1'b0;
    chk_req      = 1'b0;

    // Reset held: clocks with en=1, bit=1 must not disturb the zero state.
    for (int i = 0; i < 3; i++) shift_chk(1'b1, "reset_hold", 16'h0000);
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // Single bits from reset.
    shift_chk(1'b1, "single_1", 16'h1021);
    shift_chk(1'b0, "single_1_0", 16'h2042);
    do_reset();
    for (int i = 0; i < 8; i++) shift_chk(1'b0, "zeros", 16'h0000);

    // Asynchronous reset mid-stream, checked between clock edges.
    do_reset();
    shift_chk(1'b1, "pre_async", 16'h1021);
    shift_chk(1'b1, "pre_async2", 16'h3063);
    drive(1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", crc, 16'h0000);
    @(negedge clk);
    #1;
    rst = 1'b1;

    // "123456789" contiguous.
    ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    ascii_bits = bytes_to_bits(ascii);
    do_reset();
    feed(ascii_bits, 1'b0, "ascii_123456789", 16'h31C3);

    // Same stream with random idle gaps and junk on bit while en is low.
    do_reset();
    feed(ascii_bits, 1'b1, "ascii_gapped", 16'h31C3);

    // 512 bytes of 0xFF, then the CRC itself, MSB first.
    for (int i = 0; i < 4096; i++) ones.push_back(1'b1);
    do_reset();
    feed(ones, 1'b0, "ff_block", 16'h7FA1);
    feed(word_bits(16'h7FA1), 1'b0, "ff_block_check", 16'h0000);

    // Corrupted check word: remainder must be non-zero.
    do_reset();
    feed(ones, 1'b0, "ff_block_again", 16'h7FA1);
    tmp = ones;
    tmp = {tmp, word_bits(16'h7FA0)};
    r = ref_crc(tmp);
    check("corrupt_model_nonzero", {15'd0, (r == 16'h0000)}, 16'd0);
    feed(word_bits(16'h7FA0), 1'b0, "ff_block_corrupt", r);

    // Random messages: per-bit check against the model, then append the
    // model CRC and expect zero.
    for (int t = 0; t < 6; t++) begin
      msg.delete();
      prefix.delete();
      len = int'($urandom_range(8, 40));
      for (int i = 0; i < len; i++) msg.push_back(1'($urandom));
      do_reset();
      for (int i = 0; i < len; i++) begin
        prefix.push_back(msg[i]);
        if ($urandom_range(0, 3) == 0) idle_gap(int'($urandom_range(1, 3)));
        shift_chk(msg[i], "rand_bit", ref_crc(prefix));
      end
      feed(word_bits(ref_crc(msg)), 1'b1, "rand_check_zero", 16'h0000);
    end

    // Drain the scoreboard with a bounded wait.
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drain", 16'(sb.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sdio_crc16.md
# sdio_crc16

Serial CRC-16 generator/checker for the SDIO data path. One instance sits on each SD data line (DAT0..DAT3) inside the SDIO data PHY and accumulates the CRC-CCITT (polynomial x^16 + x^12 + x^5 + 1) over the bits sent or received on that line. The running remainder is continuously visible so the PHY can shift it out after a read block, or compare it after a write block.

## Interface
Parameters:
- none

Ports:
- clk  input  1  data-bit clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-low; clears the remainder
- en  input  1  shift enable; when high, `bit` is absorbed on this rising edge
- bit  input  1  serial data bit, MSB of each byte first (SD bus order)
- crc  output  16  current CRC remainder, registered
- crc_zero  output  1  present only with `SDIO_CRC16_ZERO_EN`; high when `crc == 16'h0000`

## Operation
- Algorithm: CRC-16/XMODEM form.
  - Initial value 16'h0000.
  - No input or output reflection; no final XOR.
- Per enabled clock:
  - feedback = `bit` ^ `crc[15]`
  - next `crc` = {`crc[14:0]`, 1'b0} ^ (feedback ? 16'h1021 : 16'h0000)
- `en` low: `crc` holds its value; `bit` is ignored.
- Check usage: after the data bits, feeding the 16 transmitted CRC bits (MSB first) leaves `crc` = 16'h0000 when there are no errors.
- There is no internal state beyond the 16-bit register. No bit counter and no state machine; framing belongs to the PHY.
- To restart the CRC for a new block, the PHY asserts `rst` low. There is no synchronous clear.

## Timing
- Reset:
  - `rst` low forces `crc` = 16'h0000 immediately, independent of `clk`.
  - `crc_zero` = 1 while in reset.
- Reset release: the first rising edge with `rst` high and `en` high absorbs the first bit.
- Latency: one cycle. A bit sampled at edge N is reflected in `crc` right after edge N.
- `crc_zero` is combinational from the `crc` register, so it has the same timing as `crc`.
- Reset asserted mid-block: the remainder is lost and `crc` = 0. No partial-state recovery.
- `en` and `bit` must be stable around the `clk` rising edge. `bit` is don't-care while `en` is low.
- Throughput: one bit per clock. Idle gaps (`en` low) between bits are allowed; the result is the same as contiguous shifting.

## Configuration
- `SDIO_CRC16_ZERO_EN` defined:
  - Adds output `crc_zero` = (`crc == 16'h0000`).
  - Used by the PHY as the good-CRC indication after shifting in data plus the received CRC.
- Not defined:
  - Port `crc_zero` does not exist.
  - The CRC datapath is identical either way.

## Test plan
- Reset: hold `rst` low, toggle `clk` with `en`=1, `bit`=1 -> `crc` stays 16'h0000. Assert `rst` low asynchronously mid-stream -> `crc` = 0 before the next edge.
- Single bits from reset:
  - shift `bit`=1 -> `crc` = 16'h1021
  - then `bit`=0 -> `crc` = 16'h2042
  - zero bits from reset -> `crc` stays 16'h0000
- ASCII "123456789", 72 bits, MSB first per byte -> `crc` = 16'h31C3.
- 512 bytes of 8'hFF (4096 bits of 1) -> `crc` = 16'h7FA1 (SD spec vector). Then shift 16'h7FA1 MSB first -> `crc` = 16'h0000, and `crc_zero` = 1 when enabled.
- Enable gating: same 9-byte stream with `en` dropped for random 1–5 cycles between bits and `bit` toggled randomly while `en` is low -> still 16'h31C3.
- Corrupted check: 4096 ones followed by 16'h7FA0 -> `crc` ≠ 0, and `crc_zero` = 0 when enabled.
